// File: rtl/alu16_seq_pkg.sv
// Shared constants for the 16-bit ALU sequencer: op enums, FSM states, flag bit positions.
// ALU16_SEQ_ADDSP_EN selects whether SEQ_ADDSP counts as a supported op.
`timescale 1ns/1ps
package alu16_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_ADD16 = 3'd0,
    SEQ_JR    = 3'd1,
    SEQ_ADDSP = 3'd2,
    SEQ_INC16 = 3'd3,
    SEQ_DEC16 = 3'd4
  } seq_op_t;

  typedef enum logic [3:0] {
    alu_NOP  = 4'd0,
    alu_ADD  = 4'd1,
    alu_ADC  = 4'd2,
    alu_ADS  = 4'd3,
    alu_INC  = 4'd4,
    alu_DEC  = 4'd5,
    alu_B    = 4'd6,
    alu_INCL = 4'd7,
    alu_DECL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  function automatic logic op_supported(input seq_op_t op);
    case (op)
      SEQ_ADD16, SEQ_JR, SEQ_INC16, SEQ_DEC16: return 1'b1;
`ifdef ALU16_SEQ_ADDSP_EN
      SEQ_ADDSP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Request, response and external-ALU signals of the 16-bit sequencer.
// slave = sequencer side; master = requester/response consumer plus the ALU.
`timescale 1ns/1ps
interface alu16_seq_if;
  import alu16_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  seq_op_t     req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_flags;

  logic [7:0]  alu_op_A;
  logic [7:0]  alu_op_B;
  alu_op_t     alu_op_code;
  logic [3:0]  alu_curr_flags;
  logic [7:0]  alu_result;
  logic [15:0] alu_addr_result;
  logic [3:0]  alu_next_flags;
  logic        alu_PC_inc_h;
  logic        alu_PC_dec_h;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_flags,
    output req_ready,
    output alu_op_A, alu_op_B, alu_op_code, alu_curr_flags,
    input  alu_result, alu_addr_result, alu_next_flags, alu_PC_inc_h, alu_PC_dec_h,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_flags,
    input  req_ready,
    input  alu_op_A, alu_op_B, alu_op_code, alu_curr_flags,
    output alu_result, alu_addr_result, alu_next_flags, alu_PC_inc_h, alu_PC_dec_h,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu16_seq.sv
// 16-bit op sequencer over an external 8-bit ALU (ADD16/JR/ADDSP/INC16/DEC16; ADDSP gated by ALU16_SEQ_ADDSP_EN).
// Latency: rsp_valid two edges after accept, one for INC16/DEC16, zero for rejected ops.
// Backpressure: accepts only in IDLE; response held stable in DONE until rsp_ready.
`timescale 1ns/1ps
module alu16_seq
  import alu16_seq_pkg::*;
(
  input logic        clk,
  input logic        rst,
  alu16_seq_if.slave bus
);

  state_t      state_q, state_d;
  seq_op_t     op_q;
  logic [15:0] a_q, b_q;
  logic [3:0]  flags_q;
  logic [7:0]  lo_q;
  logic        lo_h_q, lo_c_q, inc_q, dec_q;
  logic [15:0] rsp_result_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [3:0]  hi_flags;
  logic        unused_alu_flags;

  // Z and N from the ALU never reach the response
  assign unused_alu_flags = ^bus.alu_next_flags[FLAG_Z:FLAG_N];

  always_comb begin
    state_d            = state_q;
    bus.req_ready      = 1'b0;
    bus.alu_op_code    = alu_NOP;
    bus.alu_op_A       = 8'h00;
    bus.alu_op_B       = 8'h00;
    bus.alu_curr_flags = flags_q;
    hi_flags           = flags_q;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = op_supported(bus.req_op) ? LO : DONE;
      end
      LO: begin
        bus.alu_op_A = a_q[7:0];
        bus.alu_op_B = b_q[7:0];
        state_d      = HI;
        case (op_q)
          SEQ_ADD16, SEQ_ADDSP: bus.alu_op_code = alu_ADD;
          SEQ_JR:               bus.alu_op_code = alu_ADS;
          SEQ_INC16, SEQ_DEC16: begin
            bus.alu_op_code = (op_q == SEQ_INC16) ? alu_INCL : alu_DECL;
            bus.alu_op_A    = a_q[15:8];
            bus.alu_op_B    = a_q[7:0];
            state_d         = DONE;
          end
          default:              state_d = DONE;
        endcase
      end
      HI: begin
        // INC/DEC/B on the high byte pass a[15:8] on both operands
        bus.alu_op_A = a_q[15:8];
        bus.alu_op_B = a_q[15:8];
        state_d      = DONE;
        case (op_q)
          SEQ_ADD16: begin
            bus.alu_op_code            = alu_ADC;
            bus.alu_op_B               = b_q[15:8];
            bus.alu_curr_flags[FLAG_C] = lo_c_q;
            hi_flags = {flags_q[FLAG_Z], 1'b0,
                        bus.alu_next_flags[FLAG_H], bus.alu_next_flags[FLAG_C]};
          end
          SEQ_JR: begin
            if (inc_q)      bus.alu_op_code = alu_INC;
            else if (dec_q) bus.alu_op_code = alu_DEC;
            else            bus.alu_op_code = alu_B;
          end
          SEQ_ADDSP: begin
            if (!b_q[7] && lo_c_q)      bus.alu_op_code = alu_INC;
            else if (b_q[7] && !lo_c_q) bus.alu_op_code = alu_DEC;
            else                        bus.alu_op_code = alu_B;
            hi_flags = {2'b00, lo_h_q, lo_c_q};
          end
          default: ;
        endcase
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= SEQ_ADD16;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      flags_q      <= 4'h0;
      lo_q         <= 8'h00;
      lo_h_q       <= 1'b0;
      lo_c_q       <= 1'b0;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_flags_q  <= 4'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            a_q       <= bus.req_a;
            b_q       <= bus.req_b;
            flags_q   <= bus.req_flags;
            rsp_err_q <= !op_supported(bus.req_op);
            if (!op_supported(bus.req_op)) begin
              rsp_result_q <= bus.req_a;
              rsp_flags_q  <= bus.req_flags;
            end
          end
        end
        LO: begin
          lo_q   <= bus.alu_result;
          lo_h_q <= bus.alu_next_flags[FLAG_H];
          lo_c_q <= bus.alu_next_flags[FLAG_C];
          inc_q  <= bus.alu_PC_inc_h;
          dec_q  <= bus.alu_PC_dec_h;
          if (state_d == DONE) begin
            rsp_result_q <= bus.alu_addr_result;
            rsp_flags_q  <= flags_q;
          end
        end
        HI: begin
          rsp_result_q <= {bus.alu_result, lo_q};
          rsp_flags_q  <= hi_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU, directed vector table, corner sequences, random ops vs. 16-bit reference.
`timescale 1ns/1ps
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu16_seq_if bus();

  alu16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // External ALU; flags from INC/DEC/B/INCL/DECL are deliberately bogus
  logic [8:0]  alu_sum;
  logic [4:0]  alu_half;
  logic        alu_cin;
  logic [15:0] alu_pair;
  always_comb begin
    alu_cin              = (bus.alu_op_code == alu_ADC) && bus.alu_curr_flags[0];
    alu_sum              = {1'b0, bus.alu_op_A} + {1'b0, bus.alu_op_B} + {8'd0, alu_cin};
    alu_half             = {1'b0, bus.alu_op_A[3:0]} + {1'b0, bus.alu_op_B[3:0]} + {4'd0, alu_cin};
    alu_pair             = {bus.alu_op_A, bus.alu_op_B};
    bus.alu_result       = 8'h00;
    bus.alu_addr_result  = 16'h0000;
    bus.alu_next_flags   = bus.alu_curr_flags;
    bus.alu_PC_inc_h     = 1'b0;
    bus.alu_PC_dec_h     = 1'b0;
    case (bus.alu_op_code)
      alu_ADD, alu_ADC: begin
        bus.alu_result     = alu_sum[7:0];
        bus.alu_next_flags = {alu_sum[7:0] == 8'h00, 1'b0, alu_half[4], alu_sum[8]};
      end
      alu_ADS: begin
        bus.alu_result   = alu_sum[7:0];
        bus.alu_PC_inc_h = !bus.alu_op_B[7] && alu_sum[8];
        bus.alu_PC_dec_h = bus.alu_op_B[7] && !alu_sum[8];
      end
      alu_INC:  begin bus.alu_result = bus.alu_op_A + 8'd1; bus.alu_next_flags = ~bus.alu_curr_flags; end
      alu_DEC:  begin bus.alu_result = bus.alu_op_A - 8'd1; bus.alu_next_flags = ~bus.alu_curr_flags; end
      alu_B:    begin bus.alu_result = bus.alu_op_B;        bus.alu_next_flags = ~bus.alu_curr_flags; end
      alu_INCL: begin bus.alu_addr_result = alu_pair + 16'd1; bus.alu_next_flags = ~bus.alu_curr_flags; end
      alu_DECL: begin bus.alu_addr_result = alu_pair - 16'd1; bus.alu_next_flags = ~bus.alu_curr_flags; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // 16-bit reference computed straight from the operation definitions
  function automatic void ref_op(input seq_op_t op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, output logic [15:0] r, output logic [3:0] rf,
                                 output logic e, output int lat);
    int off;
    int sum;
    off = b[7] ? int'(b[7:0]) - 256 : int'(b[7:0]);
    r = a; rf = f; e = 1'b0; lat = 2;
    case (op)
      SEQ_ADD16: begin
        sum = int'(a) + int'(b);
        r   = 16'(sum);
        rf  = {f[3], 1'b0, (int'(a[11:0]) + int'(b[11:0])) > 4095, sum > 65535};
      end
      SEQ_JR: r = 16'(int'(a) + off);
      SEQ_ADDSP: begin
`ifdef ALU16_SEQ_ADDSP_EN
        r  = 16'(int'(a) + off);
        rf = {2'b00, (int'(a[3:0]) + int'(b[3:0])) > 15, (int'(a[7:0]) + int'(b[7:0])) > 255};
`else
        e = 1'b1; lat = 0;
`endif
      end
      SEQ_INC16: begin r = 16'(int'(a) + 1); lat = 1; end
      SEQ_DEC16: begin r = 16'(int'(a) - 1); lat = 1; end
      default: e = 1'b1;
    endcase
  endfunction

  // Edges after acceptance until rsp_valid is seen; -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic issue(input seq_op_t op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    @(negedge clk);
    check("req_ready_before_issue", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_flags = f;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic do_op(input seq_op_t op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       output logic [15:0] r, output logic [3:0] rf, output logic e, output int lat);
    issue(op, a, b, f);
    wait_rsp(lat);
    r  = bus.rsp_result;
    rf = bus.rsp_flags;
    e  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    seq_op_t     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] r;
    logic [3:0]  rf;
    logic        e;
    int          lat;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] got_r, exp_r;
  logic [3:0]  got_f, exp_f;
  logic        got_e, exp_e;
  int          got_lat, exp_lat;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  bus.req_ready, 1);
    check({tag, "_rsp_valid"},  bus.rsp_valid, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_flags"},  bus.rsp_flags, 0);
    check({tag, "_rsp_err"},    bus.rsp_err, 0);
    check({tag, "_alu_op"},     bus.alu_op_code, alu_NOP);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{SEQ_ADD16, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b0, 2};
    vecs[1] = '{SEQ_JR,    16'h12FE, 16'h0004, 4'b0101, 16'h1302, 4'b0101, 1'b0, 2};
    vecs[2] = '{SEQ_JR,    16'h1200, 16'h00FE, 4'b1011, 16'h11FE, 4'b1011, 1'b0, 2};
`ifdef ALU16_SEQ_ADDSP_EN
    vecs[3] = '{SEQ_ADDSP, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011, 1'b0, 2};
    vecs[6] = '{SEQ_ADDSP, 16'h1000, 16'h00FF, 4'b1111, 16'h0FFF, 4'b0000, 1'b0, 2};
`else
    vecs[3] = '{SEQ_ADDSP, 16'hFFF8, 16'h0008, 4'b1100, 16'hFFF8, 4'b1100, 1'b1, 0};
    vecs[6] = '{SEQ_ADDSP, 16'h1000, 16'h00FF, 4'b1111, 16'h1000, 4'b1111, 1'b1, 0};
`endif
    vecs[4] = '{SEQ_INC16, 16'hFFFF, 16'h0000, 4'b0110, 16'h0000, 4'b0110, 1'b0, 1};
    vecs[5] = '{SEQ_DEC16, 16'h0000, 16'h0000, 4'b1001, 16'hFFFF, 4'b1001, 1'b0, 1};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = SEQ_ADD16;
    bus.req_a = 16'h0; bus.req_b = 16'h0; bus.req_flags = 4'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, got_r, got_f, got_e, got_lat);
      check($sformatf("vec%0d_result", i),  got_r,   vecs[i].r);
      check($sformatf("vec%0d_flags", i),   got_f,   vecs[i].rf);
      check($sformatf("vec%0d_err", i),     got_e,   vecs[i].e);
      check($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
    end

    // Backpressure: response held for 5 cycles while a competing request is ignored
    ref_op(SEQ_ADD16, 16'h1234, 16'h1111, 4'b0000, exp_r, exp_f, exp_e, exp_lat);
    issue(SEQ_ADD16, 16'h1234, 16'h1111, 4'b0000);
    wait_rsp(got_lat);
    check("bp_latency", got_lat, exp_lat);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = SEQ_INC16;
      bus.req_a     = 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid",  bus.rsp_valid,   1);
      check("bp_req_ready",  bus.req_ready,   0);
      check("bp_rsp_result", bus.rsp_result,  exp_r);
      check("bp_rsp_flags",  bus.rsp_flags,   exp_f);
      check("bp_alu_nop",    bus.alu_op_code, alu_NOP);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_exit_idle",      bus.req_ready,   1);
    check("bp_exit_no_accept", bus.alu_op_code, alu_NOP);
    check("bp_exit_rsp_valid", bus.rsp_valid,   0);
    bus.req_valid = 1'b0;

    // Reset while in HI
    issue(SEQ_ADD16, 16'h34F0, 16'h0F20, 4'b0000);
    @(negedge clk);
    check("lo_alu_op", bus.alu_op_code, alu_ADD);
    check("lo_alu_a",  bus.alu_op_A,    8'hF0);
    check("lo_alu_b",  bus.alu_op_B,    8'h20);
    @(posedge clk);
    @(negedge clk);
    check("hi_alu_op",    bus.alu_op_code,    alu_ADC);
    check("hi_alu_a",     bus.alu_op_A,       8'h34);
    check("hi_alu_b",     bus.alu_op_B,       8'h0F);
    check("hi_curr_flag", bus.alu_curr_flags, 4'b0001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midop_reset");
    rst = 1'b0;

    for (int i = 0; i < 150; i++) begin
      seq_op_t     op;
      logic [15:0] a, b;
      logic [3:0]  f;
      op = seq_op_t'($urandom_range(0, 4));
      a  = 16'($urandom);
      b  = 16'($urandom);
      f  = 4'($urandom);
      ref_op(op, a, b, f, exp_r, exp_f, exp_e, exp_lat);
      do_op(op, a, b, f, got_r, got_f, got_e, got_lat);
      check($sformatf("rand%0d_op%0d_result", i, op),  got_r,   exp_r);
      check($sformatf("rand%0d_op%0d_flags", i, op),   got_f,   exp_f);
      check($sformatf("rand%0d_op%0d_err", i, op),     got_e,   exp_e);
      check($sformatf("rand%0d_op%0d_latency", i, op), got_lat, exp_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
- REQ-001: Parameters: none.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: req_valid  input  1  request present.
- REQ-005: req_ready  output  1  sequencer can accept a request.
- REQ-006: req_op  input  seq_op_t  operation: SEQ_ADD16, SEQ_JR, SEQ_ADDSP, SEQ_INC16, SEQ_DEC16.
- REQ-007: req_a  input  16  first operand: HL, PC, SP or rr.
- REQ-008: req_b  input  16  second operand; JR/ADDSP use only [7:0], as a signed offset.
- REQ-009: req_flags  input  4  current flags {Z,N,H,C}, bit 3 down to bit 0.
- REQ-010: alu_op_A, alu_op_B  output  8 each  ALU operands.
- REQ-011: alu_op_code  output  alu_op_t  ALU opcode.
- REQ-012: alu_curr_flags  output  4  flags presented to the ALU.
- REQ-013: alu_result  input  8  ALU 8-bit result.
- REQ-014: alu_addr_result  input  16  ALU 16-bit result.
- REQ-015: alu_next_flags  input  4  ALU flag result.
- REQ-016: alu_PC_inc_h, alu_PC_dec_h  input  1 each  ALU signed-add high-byte adjust.
- REQ-017: rsp_valid  output  1  response held.
- REQ-018: rsp_ready  input  1  consumer accepts the response.
- REQ-019: rsp_result  output  16  16-bit result.
- REQ-020: rsp_flags  output  4  final flags.
- REQ-021: rsp_err  output  1  unsupported op requested.

Function
- REQ-022: The FSM SHALL use states IDLE, LO, HI, DONE; req_ready=1 only in IDLE.
- REQ-023: A request SHALL be accepted on an edge with req_valid&&req_ready; req_op, req_a, req_b and req_flags latch and the FSM goes to LO.
- REQ-024: In IDLE and DONE, alu_op_code SHALL be alu_NOP and rsp_* SHALL come from registers only.
- REQ-025: SEQ_ADD16 SHALL run LO then HI.
  - LO: alu_ADD on a[7:0], b[7:0]; latch the low byte and its C.
  - HI: alu_ADC on a[15:8], b[15:8], with curr_flags C = latched low C.
  - Final flags: Z = req_flags Z; N=0; H and C from HI.
- REQ-026: SEQ_JR SHALL run LO then HI; flags SHALL stay unchanged.
  - LO: alu_ADS on a[7:0], b[7:0]; latch the low byte and PC_inc_h/PC_dec_h.
  - HI on a[15:8]: alu_INC if inc latched, alu_DEC if dec latched, else alu_B.
- REQ-027: SEQ_ADDSP SHALL run LO then HI.
  - LO: alu_ADD on a[7:0], b[7:0]; latch the low byte and its H, C.
  - HI on a[15:8]: alu_INC if !b[7]&&C, alu_DEC if b[7]&&!C, else alu_B.
  - Final flags: Z=0, N=0, H and C from LO.
- REQ-028: SEQ_INC16/SEQ_DEC16 SHALL run LO only, using alu_INCL/alu_DECL on {a[15:8], a[7:0]}.
  - rsp_result = alu_addr_result.
  - Flags unchanged.
  - LO goes directly to DONE.
- REQ-029: Flag outputs of the ALU for HI-step INC/DEC/B SHALL be ignored for JR and ADDSP.
- REQ-030: rsp_valid SHALL assert in DONE and hold with stable rsp_* until rsp_ready; the edge with rsp_valid&&rsp_ready SHALL return the FSM to IDLE.
- REQ-031: Latency: rsp_valid SHALL be visible two edges after acceptance for two-step ops, and one edge after for INC16/DEC16.
- REQ-032: req_valid while busy SHALL be ignored; there SHALL be no acceptance in the same cycle DONE exits.
- REQ-033: All 16-bit results SHALL wrap modulo 2^16.

Reset
- REQ-034: rst SHALL take precedence in any state, including mid-operation: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_op_code=alu_NOP, and latched operands cleared.

Configuration
- REQ-035: Macro ALU16_SEQ_ADDSP_EN controls SEQ_ADDSP.
  - Defined: SEQ_ADDSP SHALL be supported per REQ-027.
  - Undefined: SEQ_ADDSP SHALL go IDLE->DONE with no ALU activity, rsp_result=req_a, rsp_flags=req_flags, rsp_err=1.
  - rsp_err is otherwise always 0.

Structure
- REQ-036: seq_op_t, the FSM state enum and flag bit-index constants (Z=3, N=2, H=1, C=0) SHALL live in the shared constants package alongside alu_op_t.
- REQ-037: No sub-module SHALL be instantiated; the ALU stays outside, connected through the alu_* ports.

Verification
- REQ-038: ADD16 a=0x0FFF b=0x0001 flags=4'b1000 -> result 0x1000, flags 4'b1010, rsp_valid 2 edges after accept.
- REQ-039: JR a=0x12FE b=0x0004 -> 0x1302; JR a=0x1200 b=0x00FE -> 0x11FE; flags equal to input in both cases.
- REQ-040: ADDSP a=0xFFF8 b=0x0008 -> 0x0000, flags 4'b0011; with the macro undefined -> 0xFFF8, rsp_err=1.
- REQ-041: INC16 a=0xFFFF -> 0x0000, flags unchanged, rsp_valid 1 edge after accept; DEC16 a=0x0000 -> 0xFFFF.
- REQ-042: Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles: rsp_* stable, req_ready=0, a second req_valid is ignored.
  - Assert rst in HI: next cycle IDLE, all outputs at reset values.
